// File: rtl/aes_axil_blk_queue.sv
// AXI4-Lite block queue for an AES-128 core: input/output block FIFOs and an issue sequencer.
// Define AES_QUEUE_IRQ_EN to add the irq output and the IRQ_CFG register at 0x08.

module aes_axil_blk_queue_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && !i_flush && (!o_full || w_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

module aes_axil_blk_queue #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [127:0]            key,
  output logic                    key_load,
  output logic                    core_start,
  output logic                    core_dec,
  output logic [127:0]            core_din,
  input  logic                    core_done,
  input  logic [127:0]            core_dout
`ifdef AES_QUEUE_IRQ_EN
  ,
  output logic                    irq
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_IRQ    = 8'h08;
  localparam logic [7:0] ADDR_KEY3   = 8'h1C;
  localparam logic [7:0] ADDR_DIN3   = 8'h2C;
  localparam logic [7:0] ADDR_DOUT3  = 8'h4C;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_awready, r_bvalid, r_arready, r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic            r_mode, r_run, r_flush, r_key_load, r_ovf, r_unf, r_discard;
  logic [127:0]    r_key, r_din;
  logic [7:0]      w_waddr, w_raddr;
  logic            w_wr_en, w_rd_en, w_din_push, w_dout_pop, w_ovf_set, w_unf_set, w_wr_status;
  logic            w_in_pop, w_out_push, w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic [128:0]    w_in_head;
  logic [127:0]    w_out_head;
  logic [PW:0]     w_in_count, w_out_count;
  logic            w_unused;

  assign w_unused = ^{S_AXI_WSTRB, S_AXI_AWPROT, S_AXI_ARPROT};

  assign w_waddr = S_AXI_AWADDR[7:0];
  assign w_raddr = S_AXI_ARADDR[7:0];
  assign w_wr_en = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
  assign w_rd_en = r_arready && S_AXI_ARVALID;

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign key           = r_key;
  assign key_load      = r_key_load;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= !r_awready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
      if (w_wr_en)           r_bvalid <= 1'b1;
      else if (S_AXI_BREADY) r_bvalid <= 1'b0;
      r_arready <= !r_arready && S_AXI_ARVALID && !r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // A DIN3 write landing on the flush cycle is dropped without raising OVF.
  assign w_din_push  = w_wr_en && (w_waddr == ADDR_DIN3) && !r_flush;
  assign w_dout_pop  = w_rd_en && (w_raddr == ADDR_DOUT3);
  assign w_ovf_set   = w_din_push && w_in_full && !w_in_pop;
  assign w_unf_set   = w_dout_pop && w_out_empty;
  assign w_wr_status = w_wr_en && (w_waddr == ADDR_STATUS);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_mode     <= 1'b0;
      r_run      <= 1'b0;
      r_flush    <= 1'b0;
      r_key_load <= 1'b0;
      r_key      <= '0;
      r_din      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_flush    <= w_wr_en && (w_waddr == ADDR_CTRL) && S_AXI_WDATA[2];
      r_key_load <= w_wr_en && (w_waddr == ADDR_KEY3);
      if (w_wr_en) begin
        case (w_waddr)
          ADDR_CTRL: begin
            r_mode <= S_AXI_WDATA[0];
            r_run  <= S_AXI_WDATA[1];
          end
          8'h10, 8'h14, 8'h18, 8'h1C: r_key[{w_waddr[3:2], 5'd0} +: 32] <= S_AXI_WDATA;
          8'h20, 8'h24, 8'h28, 8'h2C: r_din[{w_waddr[3:2], 5'd0} +: 32] <= S_AXI_WDATA;
          default: ;
        endcase
      end
      // Set events take priority over both FLUSH and write-one-to-clear.
      if (w_ovf_set)                        r_ovf <= 1'b1;
      else if (r_flush)                     r_ovf <= 1'b0;
      else if (w_wr_status && S_AXI_WDATA[5]) r_ovf <= 1'b0;
      if (w_unf_set)                        r_unf <= 1'b1;
      else if (r_flush)                     r_unf <= 1'b0;
      else if (w_wr_status && S_AXI_WDATA[6]) r_unf <= 1'b0;
    end
  end

  aes_axil_blk_queue_fifo #(.WIDTH(129), .DEPTH(DEPTH)) u_in_fifo (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .i_flush (r_flush),
    .i_push  (w_din_push),
    .i_data  ({r_mode, S_AXI_WDATA, r_din[95:0]}),
    .i_pop   (w_in_pop),
    .o_head  (w_in_head),
    .o_count (w_in_count),
    .o_full  (w_in_full),
    .o_empty (w_in_empty)
  );

  aes_axil_blk_queue_fifo #(.WIDTH(128), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .i_flush (r_flush),
    .i_push  (w_out_push),
    .i_data  (core_dout),
    .i_pop   (w_dout_pop),
    .o_head  (w_out_head),
    .o_count (w_out_count),
    .o_full  (w_out_full),
    .o_empty (w_out_empty)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_in_pop    = 1'b0;
    w_out_push  = 1'b0;
    case (r_state)
      S_IDLE:  if (r_run && !w_in_empty && !w_out_full && !r_flush) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_in_pop    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (core_done) begin
        w_out_push  = !r_discard;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign core_start = (r_state == S_ISSUE);
  assign core_dec   = core_start && w_in_head[128];
  assign core_din   = core_start ? w_in_head[127:0] : '0;

  // A block already handed to the core when FLUSH hits must not land in the emptied output FIFO.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                          r_discard <= 1'b0;
    else if (r_state == S_WAIT && core_done)     r_discard <= 1'b0;
    else if (r_flush && r_state != S_IDLE)       r_discard <= 1'b1;
  end

`ifdef AES_QUEUE_IRQ_EN
  logic       r_irq_en, r_irq;
  logic [3:0] r_thresh;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_irq_en <= 1'b0;
      r_thresh <= 4'd1;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_en && w_waddr == ADDR_IRQ) begin
        r_irq_en <= S_AXI_WDATA[0];
        r_thresh <= S_AXI_WDATA[11:8];
      end
      r_irq <= r_irq_en && ((8'(w_out_count) >= {4'd0, r_thresh}) || r_ovf || r_unf);
    end
  end

  assign irq = r_irq;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      ADDR_CTRL:   w_rdata = {30'd0, r_run, r_mode};
      ADDR_STATUS: w_rdata = {8'd0, 8'(w_out_count), 8'(w_in_count), 1'b0, r_unf, r_ovf,
                              w_out_empty, w_out_full, w_in_empty, w_in_full, r_state != S_IDLE};
`ifdef AES_QUEUE_IRQ_EN
      ADDR_IRQ:    w_rdata = {20'd0, r_thresh, 7'd0, r_irq_en};
`endif
      8'h10, 8'h14, 8'h18, 8'h1C: w_rdata = r_key[{w_raddr[3:2], 5'd0} +: 32];
      8'h20, 8'h24, 8'h28, 8'h2C: w_rdata = r_din[{w_raddr[3:2], 5'd0} +: 32];
      8'h40, 8'h44, 8'h48, 8'h4C: if (!w_out_empty) w_rdata = w_out_head[{w_raddr[3:2], 5'd0} +: 32];
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aes_axil_blk_queue.sv
// Directed bench for aes_axil_blk_queue; a behavioural stand-in for the AES core answers core_start.

module tb_aes_axil_blk_queue;
  localparam int L = 5;
  localparam logic [127:0] KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] MASK_E = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] MASK_D = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic         S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY;
  logic [31:0]  S_AXI_WDATA;
  logic         S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0]  S_AXI_RDATA;
  logic [127:0] key, core_din, core_dout;
  logic         key_load, core_start, core_dec, core_done;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int key_loads = 0;

  always #5 clk = ~clk;

  aes_axil_blk_queue #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (3'b000),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (4'hF),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (3'b000),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .key           (key),
    .key_load      (key_load),
    .core_start    (core_start),
    .core_dec      (core_dec),
    .core_din      (core_din),
    .core_done     (core_done),
    .core_dout     (core_dout)
  );

  // Known FIPS-197 pair for the real key; any other block gets an arbitrary but fixed mapping.
  function automatic logic [127:0] core_fn(input logic [127:0] din, input logic dec);
    if (!dec && din == PT) return CT;
    if (dec && din == CT)  return PT;
    return dec ? (din ^ MASK_D) : ({din[63:0], din[127:64]} ^ MASK_E);
  endfunction

  function automatic logic [127:0] blk(input int i);
    return {32'h1000_0000 + i, 32'h2000_0000 + i, 32'h3000_0000 + i, 32'h4000_0000 + i};
  endfunction

  always @(negedge clk) begin
    if (core_start) starts++;
    if (key_load)   key_loads++;
  end

  initial begin : core_model
    logic [127:0] din;
    logic         dec;
    core_done = 1'b0;
    core_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (core_start) begin
        din = core_din;
        dec = core_dec;
        repeat (L-1) @(posedge clk);
        #1;
        core_done = 1'b1;
        core_dout = core_fn(din, dec);
        @(posedge clk); #1;
        core_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data);
    int n = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while (!S_AXI_AWREADY && n < 20) begin @(posedge clk); #1; n++; end
    check("wready_with_awready", S_AXI_WREADY, 1'b1);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(posedge clk); #1; n++; end
    if (!S_AXI_BVALID) check("bvalid_timeout", S_AXI_BVALID, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
    int n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin @(posedge clk); #1; n++; end
    if (!S_AXI_ARREADY) check("arready_timeout", S_AXI_ARREADY, 1'b1);
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    if (!S_AXI_RVALID) check("rvalid_timeout", S_AXI_RVALID, 1'b1);
    data = S_AXI_RDATA;
    @(posedge clk); #1;
  endtask

  task automatic write_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) axi_write(8'h20 + 8'(4*i), b[32*i +: 32]);
  endtask

  task automatic read_block(output logic [127:0] b);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      axi_read(8'h40 + 8'(4*i), w);
      b[32*i +: 32] = w;
    end
  endtask

  initial begin
    logic [31:0]  rd;
    logic [127:0] rb;
    int           s0;
    rst_n = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_WDATA = '0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_ctrl_outs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
                            S_AXI_BRESP, S_AXI_RRESP, key_load, core_start, core_dec}, '0);
    check("rst_rdata", S_AXI_RDATA, '0);
    check("rst_key_din", {key, core_din}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(8'h04, rd); check("status_after_reset", rd, 32'h14);

    // Key load and a single encrypt
    axi_write(8'h10, KEY[31:0]);  axi_write(8'h14, KEY[63:32]);
    axi_write(8'h18, KEY[95:64]); axi_write(8'h1C, KEY[127:96]);
    check("key_out", key, KEY);
    check("key_load_pulses", key_loads, 1);
    axi_write(8'h00, 32'h2);
    axi_read(8'h00, rd); check("ctrl_readback", rd, 32'h2);
    write_block(PT);
    repeat (20) @(posedge clk); #1;
    read_block(rb); check("enc_result", rb, CT);
    axi_read(8'h04, rd); check("status_after_enc_pop", rd, 32'h14);

    // Decrypt with MODE sampled at push
    axi_write(8'h00, 32'h3);
    write_block(CT);
    repeat (20) @(posedge clk); #1;
    read_block(rb); check("dec_result", rb, PT);

    // Overflow with RUN=0, then drain in order
    axi_write(8'h00, 32'h0);
    for (int i = 0; i < 5; i++) write_block(blk(i));
    axi_read(8'h04, rd); check("status_in_full_ovf", rd, 32'h0000_0432);
    axi_write(8'h00, 32'h2);
    repeat (60) @(posedge clk); #1;
    axi_read(8'h04, rd); check("status_out_full", rd, 32'h0004_002C);
    for (int i = 0; i < 4; i++) begin
      read_block(rb); check($sformatf("queued_result_%0d", i), rb, core_fn(blk(i), 1'b0));
    end
    axi_read(8'h04, rd); check("status_drained_ovf", rd, 32'h34);
    axi_write(8'h04, 32'h20);
    axi_read(8'h04, rd); check("ovf_w1c", rd, 32'h14);

    // Underflow
    axi_read(8'h4C, rd); check("dout3_empty_rdata", rd, 32'h0);
    axi_read(8'h04, rd); check("status_unf", rd, 32'h54);
    axi_write(8'h04, 32'h40);
    axi_read(8'h04, rd); check("unf_w1c", rd, 32'h14);

    // FLUSH while the first block is in WAIT
    axi_write(8'h00, 32'h0);
    write_block(blk(7)); write_block(blk(8));
    s0 = starts;
    axi_write(8'h00, 32'h2);
    axi_write(8'h00, 32'h6);
    repeat (20) @(posedge clk); #1;
    axi_read(8'h04, rd); check("status_after_flush", rd, 32'h14);
    axi_read(8'h00, rd); check("ctrl_after_flush", rd, 32'h2);
    check("starts_during_flush", starts - s0, 1);

    // Asynchronous reset while a block is in WAIT
    s0 = starts;
    write_block(blk(9));
    repeat (2) @(posedge clk); #1;
    check("issued_before_reset", starts - s0, 1);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_outs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
                               key_load, core_start, core_dec}, '0);
    check("midwait_rst_key_din", {key, core_din}, '0);
    check("midwait_rst_rdata", S_AXI_RDATA, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(8'h04, rd); check("status_after_midwait_reset", rd, 32'h14);
    axi_read(8'h00, rd); check("ctrl_after_midwait_reset", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
